riscv_trace_matcher: RTL and testbench

- Runtime-programmable successor to the fixed tracer instruction masks.
- NUM_CH channels each hold a mask/match pair. Every retired instruction is compared against all channels in parallel.
- Per-channel event counters count hits. Hits on capture-enabled channels push {pc, instr, hit vector} into a FIFO drained by a valid/ready trace port.
- Sits beside the core's retire stage and is configured through a simple register port.

---
 rtl/riscv_trace_matcher.sv | 168 ++++++++++++++++
 tb/tb_riscv_trace_matcher.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_matcher.sv
// Runtime-programmable retire-stream matcher: NUM_CH mask/match channels with
// per-channel hit counters and a capture FIFO drained through a valid/ready trace port.
module riscv_trace_matcher #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              retire_valid_i,
  input  logic [31:0]       retire_instr_i,
  input  logic [31:0]       retire_pc_i,
  input  logic              cfg_req_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic [31:0]       cfg_rdata_o,
  output logic              cfg_rvalid_o,
  output logic [NUM_CH-1:0] hit_o,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [31:0]       trace_pc_o,
  output logic [31:0]       trace_instr_o,
  output logic [NUM_CH-1:0] trace_hit_o
);

  localparam int                   PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]           STATUS_ADDR = 8'(4 * NUM_CH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [PTR_W:0]       LEVEL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [31:0]          mask_q  [NUM_CH];
  logic [31:0]          match_q [NUM_CH];
  logic [2:0]           ctrl_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] count_q [NUM_CH];

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] cap_hit;
  logic [31:0]       rd_data;
  logic [15:0]       ovf_q;

  logic [31:0]       fifo_pc    [FIFO_DEPTH];
  logic [31:0]       fifo_instr [FIFO_DEPTH];
  logic [NUM_CH-1:0] fifo_hit   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    level_q;

  logic cfg_wr;
  logic status_sel;
  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign cfg_wr     = cfg_req_i && cfg_we_i;
  assign status_sel = (cfg_addr_i == STATUS_ADDR);

  always_comb begin
    hit     = '0;
    cap_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c]     = retire_valid_i &&
                   ((retire_instr_i & mask_q[c]) == (match_q[c] & mask_q[c]));
      cap_hit[c] = hit[c] && ctrl_q[c][1];
    end
  end

  // A config write to COUNT takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mask_q[c]  <= '0;
        match_q[c] <= '0;
        ctrl_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_wr && cfg_addr_i == 8'(4 * c))
          mask_q[c] <= cfg_wdata_i;
        if (cfg_wr && cfg_addr_i == 8'(4 * c + 1))
          match_q[c] <= cfg_wdata_i;
        if (cfg_wr && cfg_addr_i == 8'(4 * c + 2))
          ctrl_q[c] <= cfg_wdata_i[2:0];
        if (cfg_wr && cfg_addr_i == 8'(4 * c + 3))
          count_q[c] <= cfg_wdata_i[CNT_WIDTH-1:0];
        else if (hit[c] && ctrl_q[c][0] && !(ctrl_q[c][2] && count_q[c] == CNT_MAX))
          count_q[c] <= count_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_addr_i[7:2] == 6'(c)) begin
        case (cfg_addr_i[1:0])
          2'd0:    rd_data = mask_q[c];
          2'd1:    rd_data = match_q[c];
          2'd2:    rd_data = 32'(ctrl_q[c]);
          default: rd_data = 32'(count_q[c]);
        endcase
      end
    end
    if (status_sel)
      rd_data = {8'h00, 8'(level_q), ovf_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      hit_o        <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      if (cfg_req_i)
        cfg_rdata_o <= cfg_we_i ? 32'h0 : rd_data;
      hit_o <= hit;
    end
  end

  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign push_req = |cap_hit;
  assign pop      = trace_valid_o && trace_ready_i;
  assign full     = (level_q == LEVEL_FULL);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
        2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
        default: level_q <= level_q;
      endcase
      if (cfg_wr && status_sel)
        ovf_q <= '0;
      else if (drop && ovf_q != 16'hFFFF)
        ovf_q <= ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= retire_pc_i;
      fifo_instr[wr_ptr_q] <= retire_instr_i;
      fifo_hit[wr_ptr_q]   <= cap_hit;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks after reset.
  assign trace_valid_o = (level_q != '0);
  assign trace_pc_o    = trace_valid_o ? fifo_pc[rd_ptr_q]    : '0;
  assign trace_instr_o = trace_valid_o ? fifo_instr[rd_ptr_q] : '0;
  assign trace_hit_o   = trace_valid_o ? fifo_hit[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_riscv_trace_matcher.sv
// Directed bench for riscv_trace_matcher; a second instance with 4-bit counters
// shares all inputs to exercise counter wrap, saturation and write truncation.
module tb_riscv_trace_matcher;

  localparam int NUM_CH = 4;
  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] ADD   = 32'h00208033;
  localparam logic [31:0] ADDI2 = 32'h00A00113;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        retire_valid_i, cfg_req_i, cfg_we_i, trace_ready_i;
  logic [31:0] retire_instr_i, retire_pc_i, cfg_wdata_i;
  logic [7:0]  cfg_addr_i;

  logic [31:0]       cfg_rdata, trace_pc, trace_instr;
  logic              cfg_rvalid, trace_valid;
  logic [NUM_CH-1:0] hit, trace_hit;

  logic [31:0]       w4_cfg_rdata, w4_trace_pc, w4_trace_instr;
  logic              w4_cfg_rvalid, w4_trace_valid;
  logic [NUM_CH-1:0] w4_hit, w4_trace_hit;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [31:0] rd, rd4;

  riscv_trace_matcher #(.NUM_CH(NUM_CH), .CNT_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_valid_i(retire_valid_i), .retire_instr_i(retire_instr_i), .retire_pc_i(retire_pc_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid), .hit_o(hit),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc), .trace_instr_o(trace_instr), .trace_hit_o(trace_hit)
  );

  riscv_trace_matcher #(.NUM_CH(NUM_CH), .CNT_WIDTH(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .retire_valid_i(retire_valid_i), .retire_instr_i(retire_instr_i), .retire_pc_i(retire_pc_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(w4_cfg_rdata), .cfg_rvalid_o(w4_cfg_rvalid), .hit_o(w4_hit),
    .trace_valid_o(w4_trace_valid), .trace_ready_i(trace_ready_i),
    .trace_pc_o(w4_trace_pc), .trace_instr_o(w4_trace_instr), .trace_hit_o(w4_trace_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    retire_valid_i = v;
    retire_instr_i = instr;
    retire_pc_i    = pc;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    check("wr_rvalid", 32'(cfg_rvalid), 32'd1);
    check("wr_rdata", cfg_rdata, 32'd0);
  endtask

  task automatic cfg_read(input logic [7:0] a);
    @(negedge clk);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
    @(negedge clk);
    cfg_req_i = 1'b0;
    rd  = cfg_rdata;
    rd4 = w4_cfg_rdata;
    check("rd_rvalid", 32'(cfg_rvalid), 32'd1);
  endtask

  task automatic retire_burst(input int n, input logic [31:0] instr, input logic [31:0] pc0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, instr, pc0 + 32'(4 * i));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    trace_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_tvalid", 32'(trace_valid), 32'd0);
    check("rst_tpc", trace_pc, 32'd0);
    check("rst_w4_rvalid", 32'(w4_cfg_rvalid), 32'd0);
    check("rst_w4_hit", 32'(w4_hit), 32'd0);
    check("rst_w4_tvalid", 32'(w4_trace_valid), 32'd0);
    check("rst_w4_thead", w4_trace_pc | w4_trace_instr | 32'(w4_trace_hit), 32'd0);
    rst_n = 1'b1;

    $display("[TB] decode match");
    cfg_write(8'd0, 32'h0000707F);
    cfg_write(8'd1, 32'h00000013);
    cfg_write(8'd2, 32'h1);
    cfg_read(8'd0);  check("mask0", rd, 32'h0000707F);
    @(negedge clk); drive(1'b1, ADDI1, 32'h0);
    @(negedge clk); check("hit_addi1", 32'(hit), 32'hF); drive(1'b1, ADD, 32'h4);
    @(negedge clk); check("hit_add", 32'(hit), 32'hE);   drive(1'b1, ADDI2, 32'h8);
    @(negedge clk); check("hit_addi2", 32'(hit), 32'hF); drive(1'b0, 32'h0, 32'h0);
    @(negedge clk); check("hit_idle", 32'(hit), 32'h0);
    cfg_read(8'd3);  check("count0_decode", rd, 32'd2);
    @(negedge clk);
    check("rdata_hold", cfg_rdata, 32'd2);
    check("rvalid_pulse", 32'(cfg_rvalid), 32'd0);
    check("no_capture", 32'(trace_valid), 32'd0);
    cfg_write(8'h40, 32'hDEADBEEF);
    cfg_read(8'h40); check("unmapped40", rd, 32'd0);
    cfg_read(8'd17); check("unmapped17", rd, 32'd0);

    $display("[TB] wrap and saturate");
    cfg_write(8'd10, 32'h1);
    cfg_write(8'd11, 32'hE);
    retire_burst(3, 32'h0, 32'h0);
    cfg_read(8'd11); check("wrap32", rd, 32'h11); check("wrap4", rd4, 32'h1);
    cfg_write(8'd10, 32'h5);
    cfg_read(8'd10); check("ctrl2", rd, 32'h5);
    cfg_write(8'd11, 32'hE);
    retire_burst(3, 32'h0, 32'h0);
    cfg_read(8'd11); check("sat32", rd, 32'h11); check("sat4", rd4, 32'hF);
    cfg_write(8'd11, 32'hFFFFFFFF);
    retire_burst(1, 32'h0, 32'h0);
    cfg_read(8'd11); check("sat32_max", rd, 32'hFFFFFFFF); check("sat4_max", rd4, 32'hF);
    cfg_write(8'd10, 32'h1);
    retire_burst(1, 32'h0, 32'h0);
    cfg_read(8'd11); check("wrap32_max", rd, 32'h0); check("wrap4_max", rd4, 32'h0);
    cfg_write(8'd10, 32'h0);
    cfg_read(8'd3);  check("count0_untouched", rd, 32'd2);

    $display("[TB] overlap and capture");
    cfg_write(8'd2, 32'h3);
    cfg_write(8'd4, 32'h7F);
    cfg_write(8'd5, 32'h13);
    cfg_write(8'd6, 32'h2);
    @(negedge clk); drive(1'b1, ADDI1, 32'h100);
    #1 check("no_fallthrough", 32'(trace_valid), 32'd0);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0);
    check("cap_hit_o", 32'(hit), 32'hF);
    check("cap_tvalid", 32'(trace_valid), 32'd1);
    check("cap_pc", trace_pc, 32'h100);
    check("cap_instr", trace_instr, ADDI1);
    check("cap_hitvec", 32'(trace_hit), 32'h3);
    cfg_read(8'd3);  check("count0_cap", rd, 32'd3);
    cfg_read(8'd7);  check("count1_cap", rd, 32'd0);
    cfg_read(8'd16); check("status_lvl1", rd, 32'h00010000);
    check("cap_pc_stall", trace_pc, 32'h100);
    @(negedge clk); trace_ready_i = 1'b1;
    @(negedge clk); trace_ready_i = 1'b0;
    check("cap_popped", 32'(trace_valid), 32'd0);

    $display("[TB] overflow");
    retire_burst(10, ADDI1, 32'h200);
    cfg_read(8'd16); check("status_ovf", rd, 32'h00080002);
    check("ovf_head", trace_pc, 32'h200);
    @(negedge clk);
    check("ovf_head_stable", trace_pc, 32'h200);
    check("ovf_instr_stable", trace_instr, ADDI1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("full_pushpop_head", trace_pc, 32'h200 + 32'(4 * k));
      trace_ready_i = 1'b1;
      drive(1'b1, ADDI1, 32'h300 + 32'(4 * k));
    end
    @(negedge clk);
    trace_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("full_pushpop_next", trace_pc, 32'h218);
    cfg_read(8'd16); check("status_nodrop", rd, 32'h00080002);
    cfg_write(8'd16, 32'h0);
    cfg_read(8'd16); check("status_clear", rd, 32'h00080000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("drain_pc", trace_pc, (k < 2) ? 32'h218 + 32'(4 * k) : 32'h300 + 32'(4 * (k - 2)));
      trace_ready_i = 1'b1;
    end
    @(negedge clk);
    trace_ready_i = 1'b0;
    check("drain_empty", 32'(trace_valid), 32'd0);

    $display("[TB] collision");
    @(negedge clk);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 8'd3; cfg_wdata_i = 32'h50;
    drive(1'b1, ADDI1, 32'h400);
    @(negedge clk);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("coll_rvalid", 32'(cfg_rvalid), 32'd1);
    cfg_read(8'd3); check("coll_count0", rd, 32'h50); check("coll_trunc4", rd4, 32'h0);
    retire_burst(4, ADDI1, 32'h404);
    cfg_read(8'd16); check("status_lvl5", rd, 32'h00050000);
    cfg_read(8'd3);  check("count0_pre_rst", rd, 32'h54); check("count0_4_pre_rst", rd4, 32'h4);
    check("head_pre_rst", trace_pc, 32'h400);

    $display("[TB] reset mid-operation");
    @(negedge clk); drive(1'b1, ADDI1, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_tvalid", 32'(trace_valid), 32'd0);
    check("mrst_tpc", trace_pc, 32'd0);
    check("mrst_tinstr", trace_instr, 32'd0);
    check("mrst_thit", 32'(trace_hit), 32'd0);
    check("mrst_hit", 32'(hit), 32'd0);
    check("mrst_rdata", cfg_rdata, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a <= 16; a++) begin
      cfg_read(8'(a));
      check($sformatf("post_rst_reg%0d", a), rd, 32'd0);
      check($sformatf("post_rst_w4_reg%0d", a), rd4, 32'd0);
    end
    check("post_rst_tvalid", 32'(trace_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
